// File: rtl/ara_eoc_pkg.sv
// Shared types and constants for the Ara end-of-computation monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ara_eoc_pkg;

    // Per-channel benchmark phase.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eoc_state_e;

    // Field widths of the register-map view of one channel. These match the
    // monitor's default parameters.
    localparam int unsigned EocCntWidth  = 64;
    localparam int unsigned EocExitWidth = 64;
    localparam int unsigned EocCodeWidth = EocExitWidth - 1;

    // Default bound on the number of cycles spent waiting for the vector
    // engine to go idle after a stop marker.
    localparam int unsigned DefaultDrainTimeout = 1024;

    // One channel's status as read by the control-register block.
    typedef struct packed {
        logic [EocCntWidth-1:0]  cycles;
        logic                    done;
        logic                    timeout;
        logic                    exit_valid;
        logic [EocCodeWidth-1:0] exit_code;
    } eoc_chan_status_t;

endpackage

// File: rtl/ara_eoc_channel.sv
// One hart/Ara channel: benchmark cycle counter FSM plus first-exit-word latch.
// Latency: all outputs registered, updated on the edge that samples the input.
// Backpressure: none; pulses are sampled every cycle and never stalled.
//
// Ports:
//   clk_i, rst_i, clear_i      clock, sync active-high reset, sync soft clear
//   exit_i                     tohost-style word, bit0 = valid, [W-1:1] = code
//   busy_i                     vector engine still has instructions in flight
//   start_i, stop_i            benchmark marker pulses
//   cycles_o                   saturating cycle count of the current/last run
//   done_o, timeout_o          run finished / finished by drain timeout
//   exit_valid_o, exit_code_o  first exit word seen and its code
module ara_eoc_channel
    import ara_eoc_pkg::*;
#(
    parameter int unsigned CntWidth     = 64,
    parameter int unsigned ExitWidth    = 64,
    parameter int unsigned DrainTimeout = DefaultDrainTimeout
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic [ExitWidth-1:0] exit_i,
    input  logic                 busy_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    output logic [CntWidth-1:0]  cycles_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic                 exit_valid_o,
    output logic [ExitWidth-2:0] exit_code_o
);

    // The drain counter only needs to reach DrainTimeout-1.
    localparam int unsigned DrainWidth = (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
    localparam logic [DrainWidth-1:0] DrainLast = DrainWidth'(DrainTimeout - 1);

    eoc_state_e            state_q, state_d;
    logic [CntWidth-1:0]   cycles_q, cycles_d;
    logic [DrainWidth-1:0] drain_q, drain_d;
    logic                  timeout_q, timeout_d;
    logic                  exit_valid_q, exit_valid_d;
    logic [ExitWidth-2:0]  exit_code_q, exit_code_d;
    logic [CntWidth-1:0]   cycles_inc;

    always_comb begin
        state_d      = state_q;
        cycles_d     = cycles_q;
        drain_d      = drain_q;
        timeout_d    = timeout_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;

        // Saturate rather than wrap so an overlong run reads as "at least max".
        cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                // A stop arriving with the start is dropped: start wins.
                if (start_i) begin
                    state_d  = COUNT;
                    cycles_d = '0;
                end
            end
            COUNT: begin
                cycles_d = cycles_inc;
                if (stop_i) begin
                    if (busy_i) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                cycles_d = cycles_inc;
                drain_d  = drain_q + 1'b1;
                // Engine going idle takes priority over the timeout on the
                // same cycle, so a just-in-time drain is not flagged.
                if (!busy_i) begin
                    state_d = DONE;
                end else if (drain_q == DrainLast) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_d   = COUNT;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Only the first valid exit word is kept; independent of the FSM.
        if (exit_i[0] && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_code_d  = exit_i[ExitWidth-1:1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q      <= IDLE;
            cycles_q     <= '0;
            drain_q      <= '0;
            timeout_q    <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            drain_q      <= drain_d;
            timeout_q    <= timeout_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
        end
    end

    assign cycles_o     = cycles_q;
    assign done_o       = (state_q == DONE);
    assign timeout_o    = timeout_q;
    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;

endmodule

// File: rtl/ara_eoc_monitor.sv
// Multi-channel end-of-computation / benchmark monitor with global finish/fail.
// Latency: per-channel outputs 1 cycle; all_exit_o/finish_o 1 cycle after the last latch; fail_o comb.
// Backpressure: none; every input is sampled each cycle.
//
// Ports:
//   clk_i, rst_i, clear_i   clock, sync active-high reset, sync soft clear
//   exit_i, busy_i          per-channel exit word and vector-engine busy
//   start_i, stop_i         per-channel benchmark marker pulses
//   cycles_o, bench_done_o, timeout_o, exit_valid_o, exit_code_o  per channel
//   all_exit_o, fail_o, finish_o  aggregated status
module ara_eoc_monitor
    import ara_eoc_pkg::*;
#(
    parameter int unsigned NrChannels   = 4,
    parameter int unsigned CntWidth     = 64,
    parameter int unsigned ExitWidth    = 64,
    parameter int unsigned DrainTimeout = DefaultDrainTimeout
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic [NrChannels-1:0][ExitWidth-1:0]  exit_i,
    input  logic [NrChannels-1:0]                 busy_i,
    input  logic [NrChannels-1:0]                 start_i,
    input  logic [NrChannels-1:0]                 stop_i,
    output logic [NrChannels-1:0][CntWidth-1:0]   cycles_o,
    output logic [NrChannels-1:0]                 bench_done_o,
    output logic [NrChannels-1:0]                 timeout_o,
    output logic [NrChannels-1:0]                 exit_valid_o,
    output logic [NrChannels-1:0][ExitWidth-2:0]  exit_code_o,
    output logic                                  all_exit_o,
    output logic                                  fail_o,
    output logic                                  finish_o
);

    logic [NrChannels-1:0] code_nz;
    logic                  all_exit_q, all_exit_d;
    logic                  finish_q, finish_d;

    for (genvar c = 0; c < NrChannels; c++) begin : g_chan
        ara_eoc_channel #(
            .CntWidth    (CntWidth),
            .ExitWidth   (ExitWidth),
            .DrainTimeout(DrainTimeout)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clear_i     (clear_i),
            .exit_i      (exit_i[c]),
            .busy_i      (busy_i[c]),
            .start_i     (start_i[c]),
            .stop_i      (stop_i[c]),
            .cycles_o    (cycles_o[c]),
            .done_o      (bench_done_o[c]),
            .timeout_o   (timeout_o[c]),
            .exit_valid_o(exit_valid_o[c]),
            .exit_code_o (exit_code_o[c])
        );

        assign code_nz[c] = |exit_code_o[c];
    end

    always_comb begin
        all_exit_d = &exit_valid_o;
        // Registered so the pulse coincides with the first cycle all_exit_o is high.
        finish_d   = all_exit_d & ~all_exit_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            all_exit_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            all_exit_q <= all_exit_d;
            finish_q   <= finish_d;
        end
    end

    assign all_exit_o = all_exit_q;
    assign finish_o   = finish_q;
    assign fail_o     = |(exit_valid_o & code_nz);

endmodule

// File: tb/tb_ara_eoc_monitor.sv
module tb_ara_eoc_monitor;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int EW  = 8;
    localparam int DT  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic                    rst, clr;
    logic [NCH-1:0][EW-1:0]  exit_w;
    logic [NCH-1:0]          busy, start, stop;
    logic [NCH-1:0][CW-1:0]  cycles;
    logic [NCH-1:0]          done, tout, vld;
    logic [NCH-1:0][EW-2:0]  code;
    logic                    all_exit, fail, finish;

    ara_eoc_monitor #(
        .NrChannels(NCH), .CntWidth(CW), .ExitWidth(EW), .DrainTimeout(DT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .exit_i(exit_w), .busy_i(busy),
        .start_i(start), .stop_i(stop), .cycles_o(cycles), .bench_done_o(done),
        .timeout_o(tout), .exit_valid_o(vld), .exit_code_o(code),
        .all_exit_o(all_exit), .fail_o(fail), .finish_o(finish)
    );

    // Narrow-counter instance for the saturation corner
    logic                  s_rst, s_clr;
    logic [0:0][EW-1:0]    s_exit;
    logic [0:0]            s_busy, s_start, s_stop;
    logic [0:0][3:0]       s_cycles;
    logic [0:0]            s_done, s_tout, s_vld;
    logic [0:0][EW-2:0]    s_code;
    logic                  s_all_exit, s_fail, s_finish;

    ara_eoc_monitor #(
        .NrChannels(1), .CntWidth(4), .ExitWidth(EW), .DrainTimeout(DT)
    ) dut_sat (
        .clk_i(clk), .rst_i(s_rst), .clear_i(s_clr), .exit_i(s_exit), .busy_i(s_busy),
        .start_i(s_start), .stop_i(s_stop), .cycles_o(s_cycles), .bench_done_o(s_done),
        .timeout_o(s_tout), .exit_valid_o(s_vld), .exit_code_o(s_code),
        .all_exit_o(s_all_exit), .fail_o(s_fail), .finish_o(s_finish)
    );

    typedef struct {
        string                  name;
        int                     ncyc;
        logic                   rst, clr;
        logic [NCH-1:0]         start, stop, busy;
        logic [NCH-1:0][EW-1:0] exitw;
        logic [NCH-1:0][CW-1:0] cyc;
        logic [NCH-1:0]         done, tout, vld;
        logic [NCH-1:0][EW-2:0] code;
        logic                   all_exit, finish, fail;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t cur;
    vec_t e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_exp();
        cur.cyc      = '0;
        cur.done     = '0;
        cur.tout     = '0;
        cur.vld      = '0;
        cur.code     = '0;
        cur.all_exit = 1'b0;
        cur.finish   = 1'b0;
        cur.fail     = 1'b0;
    endtask

    // Record current stimulus+expectation; pulses are cleared for the next record.
    task automatic add(input string name, input int n);
        cur.name = name;
        cur.ncyc = n;
        tbl.push_back(cur);
        cur.rst   = 1'b0;
        cur.clr   = 1'b0;
        cur.start = '0;
        cur.stop  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- build vector table ----------------
        cur.rst = 1'b0; cur.clr = 1'b0;
        cur.start = '0; cur.stop = '0; cur.busy = '0; cur.exitw = '0;
        zero_exp();

        cur.rst = 1'b1; cur.exitw = {NCH{8'h01}};     add("reset_hold", 3);
        cur.vld = 4'hF;                               add("exit_latch", 1);
        cur.all_exit = 1'b1; cur.finish = 1'b1;       add("finish_pulse", 1);
        cur.finish = 1'b0;                            add("finish_once", 1);
        cur.exitw = '0;                               add("exit_drop", 1);
        cur.clr = 1'b1; zero_exp();                   add("clear", 1);
        cur.stop = 4'b0001;                           add("stop_in_idle", 1);
        add("idle", 3);
        // ch0: plain count, stop with engine idle
        cur.start = 4'b0001;                          add("ch0_start", 1);
        cur.cyc[0] = 9;                               add("ch0_count", 9);
        cur.stop = 4'b0001; cur.cyc[0] = 10; cur.done[0] = 1'b1; add("ch0_stop", 1);
        add("ch0_hold", 5);
        // ch1: stop while busy, drain 7 cycles
        cur.start = 4'b0010;                          add("ch1_start", 1);
        cur.busy = 4'b0010; cur.cyc[1] = 19;          add("ch1_count", 19);
        cur.stop = 4'b0010; cur.cyc[1] = 20;          add("ch1_stop_busy", 1);
        cur.cyc[1] = 25;                              add("ch1_drain", 5);
        cur.start = 4'b0010; cur.cyc[1] = 26;         add("ch1_drain_start_ign", 1);
        cur.busy = '0; cur.cyc[1] = 27; cur.done[1] = 1'b1; add("ch1_idle_done", 1);
        // ch2: drain timeout, then re-start
        cur.start = 4'b0100;                          add("ch2_start", 1);
        cur.busy = 4'b0100; cur.cyc[2] = 3;           add("ch2_count", 3);
        cur.stop = 4'b0100; cur.cyc[2] = 4;           add("ch2_stop_busy", 1);
        cur.cyc[2] = 11;                              add("ch2_drain", 7);
        cur.cyc[2] = 12; cur.done[2] = 1'b1; cur.tout[2] = 1'b1; add("ch2_timeout", 1);
        cur.busy = '0;                                add("ch2_hold", 2);
        cur.start = 4'b0100; cur.cyc[2] = 0; cur.done[2] = 1'b0; cur.tout[2] = 1'b0;
        add("ch2_restart", 1);
        cur.cyc[2] = 5;                               add("ch2_recount", 5);
        cur.stop = 4'b0100; cur.cyc[2] = 6; cur.done[2] = 1'b1; add("ch2_stop", 1);
        // ch3: start+stop together in IDLE, start ignored in COUNT
        cur.start = 4'b1000; cur.stop = 4'b1000;      add("ch3_start_stop", 1);
        cur.cyc[3] = 4;                               add("ch3_count", 4);
        cur.start = 4'b1000; cur.cyc[3] = 5;          add("ch3_start_ign", 1);
        cur.stop = 4'b1000; cur.cyc[3] = 6; cur.done[3] = 1'b1; add("ch3_stop", 1);
        // exit words and fail
        cur.exitw[0] = 8'h01; cur.exitw[1] = 8'h01; cur.exitw[2] = 8'h01; cur.exitw[3] = 8'h07;
        cur.vld = 4'hF; cur.code[3] = 7'd3; cur.fail = 1'b1;      add("exit_codes", 1);
        cur.exitw[3] = 8'h09; cur.all_exit = 1'b1; cur.finish = 1'b1; add("exit_second_ign", 1);
        cur.exitw = '0; cur.finish = 1'b0;            add("exit_after", 1);
        cur.clr = 1'b1; zero_exp();                   add("clear_all", 1);
        add("after_clear", 2);

        // ---------------- sat instance held in reset meanwhile ----------------
        s_rst = 1'b1; s_clr = 1'b0; s_exit = '0; s_busy = '0; s_start = '0; s_stop = '0;

        // ---------------- apply table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            rst    = tbl[i].rst;
            clr    = tbl[i].clr;
            start  = tbl[i].start;
            stop   = tbl[i].stop;
            busy   = tbl[i].busy;
            exit_w = tbl[i].exitw;
            sb.push_back(tbl[i]);
            repeat (tbl[i].ncyc) @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.name, ".cycles"},   64'(cycles),   64'(e.cyc));
            chk({e.name, ".done"},     64'(done),     64'(e.done));
            chk({e.name, ".timeout"},  64'(tout),     64'(e.tout));
            chk({e.name, ".exit_vld"}, 64'(vld),      64'(e.vld));
            chk({e.name, ".exit_code"},64'(code),     64'(e.code));
            chk({e.name, ".all_exit"}, 64'(all_exit), 64'(e.all_exit));
            chk({e.name, ".finish"},   64'(finish),   64'(e.finish));
            chk({e.name, ".fail"},     64'(fail),     64'(e.fail));
        end

        // ---------------- saturation with a 4-bit counter ----------------
        @(posedge clk); #1;
        chk("sat.reset_cycles", 64'(s_cycles), 64'd0);
        s_rst = 1'b0; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        chk("sat.start", 64'(s_cycles), 64'd0);
        repeat (14) @(posedge clk);
        #1;
        chk("sat.count14", 64'(s_cycles), 64'd14);
        @(posedge clk); #1;
        chk("sat.count15", 64'(s_cycles), 64'd15);
        repeat (5) @(posedge clk);
        #1;
        chk("sat.held", 64'(s_cycles), 64'd15);
        s_stop = 1'b1;
        @(posedge clk); #1;
        s_stop = 1'b0;
        chk("sat.stop_cycles", 64'(s_cycles), 64'd15);
        chk("sat.stop_done",   64'(s_done),   64'd1);
        chk("sat.fail",        64'(s_fail),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ara_eoc_monitor.md
Name: ara_eoc_monitor

Overview:
- Synthesizable, multi-channel end-of-computation and benchmark monitor. Used in the Ara testharness and in the SoC control-register path.
- Per channel (one hart/Ara pair):
  - latches the tohost-style exit word;
  - counts benchmark cycles between start and stop markers;
  - holds the count open until the vector engine reports idle.
- Aggregates all channels into global finish/fail status so the bench and the AXI-lite regs read one block.

Parameters:
- NrChannels, 4, number of monitored hart/Ara pairs (1..16)
- CntWidth, 64, cycle-counter width per channel
- ExitWidth, 64, width of the exit word; bit0 = valid, bits [ExitWidth-1:1] = code
- DrainTimeout, 1024, max cycles spent in DRAIN before a forced stop (must be ≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous soft clear of all channels (same effect as reset)
- exit_i  in  NrChannels×ExitWidth  per-channel exit word
- busy_i  in  NrChannels  per-channel vector engine busy (OR of running insns)
- start_i  in  NrChannels  per-channel benchmark start pulse
- stop_i  in  NrChannels  per-channel benchmark stop pulse
- cycles_o  out  NrChannels×CntWidth  per-channel cycle count
- bench_done_o  out  NrChannels  channel in DONE state
- timeout_o  out  NrChannels  sticky: channel DONE was reached by DrainTimeout
- exit_valid_o  out  NrChannels  sticky: exit word latched
- exit_code_o  out  NrChannels×(ExitWidth-1)  latched exit code
- all_exit_o  out  1  all channels exit_valid_o
- fail_o  out  1  any latched exit code ≠ 0
- finish_o  out  1  one-cycle pulse on rising edge of all_exit_o

Behaviour:
- Reset or clear_i (synchronous, highest priority):
  - all channel states go to IDLE;
  - all outputs read 0: cycles, flags, codes, drain counters.
- Per-channel FSM IDLE→COUNT→(DRAIN)→DONE:
  - IDLE: start_i → COUNT with cycles=0. stop_i in IDLE is ignored. Simultaneous start_i and stop_i in IDLE: start wins, stop dropped.
  - COUNT: cycles +1 every cycle.
    - stop_i with busy_i=0 → DONE; that cycle is counted.
    - stop_i with busy_i=1 → DRAIN with drain counter=0.
    - start_i is ignored.
  - DRAIN: cycles +1 every cycle, drain counter +1.
    - busy_i=0 → DONE; that cycle is counted.
    - Otherwise, drain counter reaching DrainTimeout-1 → DONE with timeout_o=1.
    - start_i and stop_i are ignored.
  - DONE: cycles held; bench_done_o=1. start_i re-arms: → COUNT, cycles=0, timeout_o cleared.
- Counter saturates at all-ones; no wrap.
- Count example: start at edge k, stop at edge k+10 with busy low → cycles_o=10 from edge k+10 onward.
- Exit latch:
  - On the first cycle exit_i[c][0]=1 while exit_valid_o[c]=0, latch exit_i[c]>>1 into exit_code_o[c] and set exit_valid_o[c].
  - Later exit words are ignored until reset/clear.
  - Exit latching is independent of the FSM.
- all_exit_o = &exit_valid_o, registered 1 cycle after the last latch.
- finish_o = all_exit_o & ~all_exit_o_q.
- fail_o = OR over channels of (exit_valid_o & |exit_code_o), combinational from registers.
- All outputs are registered except fail_o. Channels are fully independent; no cross-channel arbitration.

Decomposition:
- Package ara_eoc_pkg:
  - eoc_state_e enum (IDLE, COUNT, DRAIN, DONE);
  - eoc_chan_status_t struct (cycles, done, timeout, exit_valid, exit_code), parametrised by field-width localparams;
  - default DrainTimeout constant.
- Sub-module ara_eoc_channel:
  - one FSM, cycle counter, drain counter and exit latch;
  - instantiated NrChannels times via generate.
- The top does aggregation and the finish_o edge detect.

Test Plan:
- Reset: hold rst_i 3 cycles with exit_i=1 on all channels → all outputs 0 during reset. All exits latch one cycle after release; finish_o pulses once.
- Count no-drain: ch0 start at cycle 5, stop at cycle 15, busy=0 → cycles_o[0]=10, bench_done_o[0]=1 at cycle 16; ch1..3 stay IDLE with cycles 0.
- Drain: ch1 start at t, stop at t+20, busy held high until t+27 then low → DRAIN 7 cycles, cycles_o[1]=27, timeout_o[1]=0.
- Timeout: DrainTimeout=8, ch2 busy stuck high after stop at t+4 → DONE at t+12, cycles_o[2]=12, timeout_o[2]=1. Re-start clears to 0 and counts again.
- Exit/fail: ch0..2 exit_i=1 (code 0), ch3 exit_i=0x7 (code 3) then 0x9 → exit_code_o[3]=3 (second word ignored), fail_o=1, finish_o one pulse. clear_i → all zero, no finish pulse.
- Corner cases:
  - start+stop same cycle in IDLE → COUNT only;
  - CntWidth=4 run of 20 cycles → cycles_o saturates at 15.
